// File: rtl/instr_fetch_if.sv
// Bus bundle between the fetch unit, instruction memory and the decoder/datapath.
// master: fetch unit side. slave: memory + datapath side.
interface instr_fetch_if #(
    parameter int XLEN = 32
);
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_gnt;
    logic            imem_rvalid;
    logic [XLEN-1:0] imem_rdata;
    logic            instr_valid;
    logic            instr_ready;
    logic [XLEN-1:0] instr;
    logic [6:0]      opcode;
    logic [XLEN-1:0] pc_out;
    logic            branch_taken;
    logic [XLEN-1:0] branch_target;
    logic            fetch_err;

    modport master (
        output imem_req, imem_addr, instr_valid, instr, opcode, pc_out, fetch_err,
        input  imem_gnt, imem_rvalid, imem_rdata, instr_ready, branch_taken, branch_target
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, instr, opcode, pc_out, fetch_err,
        output imem_gnt, imem_rvalid, imem_rdata, instr_ready, branch_taken, branch_target
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches one word at a time from
// instruction memory and hands it to the decoder over a valid/ready handshake.
// Optional macro FETCH_MISALIGN_CHECK_EN: a taken branch to a target with
// nonzero low bits parks the unit in a sticky error state.
//
// state  | meaning
// -------+-----------------------------------------------------------
// REQ    | request outstanding at pc, waiting for imem_gnt
// WAIT   | granted, waiting for imem_rvalid (unbounded latency)
// HOLD   | instruction held for the datapath until accepted
// ERR    | misaligned branch target seen, sticky until reset (macro only)
module instr_fetch_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              PC_STEP  = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    instr_fetch_if.master bus
);
    localparam logic [1:0] S_REQ  = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;
`ifdef FETCH_MISALIGN_CHECK_EN
    localparam logic [1:0] S_ERR  = 2'd3;
`endif

    logic [1:0]      state;
    logic            started;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr_q;
    logic [XLEN-1:0] pc_out_q;
    logic            valid_q;
    logic            accept;

    assign accept = valid_q && bus.instr_ready;

    // started holds the request off for the first edge after reset release
    assign bus.imem_req    = started && (state == S_REQ);
    assign bus.imem_addr   = pc;
    assign bus.instr_valid = valid_q;
    assign bus.instr       = instr_q;
    assign bus.opcode      = instr_q[6:0];
    assign bus.pc_out      = pc_out_q;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic err_q;
    logic misalign;
    assign misalign      = bus.branch_taken && (bus.branch_target[1:0] != 2'b00);
    assign bus.fetch_err = err_q;
`else
    assign bus.fetch_err = 1'b0;
`endif

    // Fetch sequencing: request, wait for data, hold until the datapath retires it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_REQ;
            started  <= 1'b0;
            pc       <= RESET_PC;
            instr_q  <= '0;
            pc_out_q <= '0;
            valid_q  <= 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
            err_q    <= 1'b0;
`endif
        end else begin
            started <= 1'b1;
            case (state)
                S_REQ: begin
                    // rvalid is ignored here so a stale pre-reset response is dropped
                    if (started && bus.imem_gnt) begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (bus.imem_rvalid) begin
                        instr_q  <= bus.imem_rdata;
                        pc_out_q <= pc;
                        valid_q  <= 1'b1;
                        state    <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (accept) begin
                        valid_q <= 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
                        if (misalign) begin
                            err_q <= 1'b1;
                            state <= S_ERR;
                        end else
`endif
                        begin
                            pc    <= bus.branch_taken ? bus.branch_target
                                                      : pc + XLEN'(PC_STEP);
                            state <= S_REQ;
                        end
                    end
                end
`ifdef FETCH_MISALIGN_CHECK_EN
                S_ERR: begin
                    state <= S_ERR;
                end
`endif
                default: begin
                    state <= S_REQ;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: table vectors, randomized
// transactions against a PC model, and hand sequences for reset/wrap/misalign.
module tb_instr_fetch_unit;
    logic clk;
    logic rst_n;

    instr_fetch_if #(.XLEN(32)) bus ();
    instr_fetch_if #(.XLEN(32)) wbus ();

    instr_fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000), .PC_STEP(4)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    instr_fetch_unit #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC), .PC_STEP(4)) dut_w (
        .clk(clk), .rst_n(rst_n), .bus(wbus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Wrap DUT: always-grant memory with one-cycle response, ready follows valid
    logic [31:0] w_log[$];
    logic        w_pend;
    initial begin
        wbus.imem_gnt      = 1'b0;
        wbus.imem_rvalid   = 1'b0;
        wbus.imem_rdata    = 32'h0000_0013;
        wbus.instr_ready   = 1'b0;
        wbus.branch_taken  = 1'b0;
        wbus.branch_target = 32'h0;
        w_pend = 1'b0;
        forever begin
            @(negedge clk);
            wbus.imem_rvalid = w_pend;
            w_pend = 1'b0;
            wbus.imem_gnt = wbus.imem_req;
            if (wbus.imem_req) begin
                w_pend = 1'b1;
                w_log.push_back(wbus.imem_addr);
            end
            wbus.instr_ready = wbus.instr_valid;
        end
    end

    typedef struct {
        int          gd;      // REQ cycles before gnt
        int          rd;      // extra WAIT cycles before rvalid
        int          hd;      // HOLD cycles with ready low (branch noise applied)
        bit          stale;   // rvalid alongside gnt in REQ
        bit          tk;
        logic [31:0] tgt;
        logic [31:0] word;
        logic [31:0] exp_addr;
        logic [31:0] exp_next;
    } vec_t;

    vec_t vecs[8];

    // One full instruction, entered and left at a negedge in REQ
    task automatic fetch(input int gd, input int rd, input int hd, input bit stale,
                         input bit tk, input logic [31:0] tgt, input logic [31:0] word,
                         input logic [31:0] ea, input logic [31:0] en, input bit exp_err);
        chk("req_start", bus.imem_req, 1);
        chk("addr_start", bus.imem_addr, ea);
        for (int i = 0; i < gd; i++) begin
            @(negedge clk);
            chk("req_stable", bus.imem_req, 1);
            chk("addr_stable", bus.imem_addr, ea);
            chk("valid_in_req", bus.instr_valid, 0);
        end
        bus.imem_gnt    = 1'b1;
        bus.imem_rvalid = stale;
        bus.imem_rdata  = ~word;
        @(negedge clk);
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b0;
        chk("req_drop", bus.imem_req, 0);
        chk("valid_in_wait", bus.instr_valid, 0);
        for (int i = 0; i < rd; i++) begin
            @(negedge clk);
            chk("wait_valid", bus.instr_valid, 0);
            chk("wait_req", bus.imem_req, 0);
        end
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = word;
        @(negedge clk);
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = $urandom;
        chk("valid_rise", bus.instr_valid, 1);
        chk("instr", bus.instr, word);
        chk("opcode", {25'b0, bus.opcode}, {25'b0, word[6:0]});
        chk("pc_out", bus.pc_out, ea);
        for (int i = 0; i < hd; i++) begin
            bus.branch_taken  = 1'b1;
            bus.branch_target = 32'hDEAD_BEE0;
            @(negedge clk);
            chk("hold_valid", bus.instr_valid, 1);
            chk("hold_instr", bus.instr, word);
            chk("hold_opcode", {25'b0, bus.opcode}, {25'b0, word[6:0]});
            chk("hold_pc_out", bus.pc_out, ea);
            chk("hold_no_req", bus.imem_req, 0);
        end
        bus.instr_ready   = 1'b1;
        bus.branch_taken  = tk;
        bus.branch_target = tgt;
        @(negedge clk);
        bus.instr_ready   = 1'b0;
        bus.branch_taken  = 1'b0;
        bus.branch_target = 32'h0;
        chk("valid_fall", bus.instr_valid, 0);
        if (exp_err) begin
            chk("err_req", bus.imem_req, 0);
            chk("err_flag", bus.fetch_err, 1);
        end else begin
            chk("next_req", bus.imem_req, 1);
            chk("next_addr", bus.imem_addr, en);
            chk("no_err", bus.fetch_err, 0);
        end
    endtask

    task automatic reset_outputs_chk(input string tag);
        chk({tag, "_req"}, bus.imem_req, 0);
        chk({tag, "_valid"}, bus.instr_valid, 0);
        chk({tag, "_instr"}, bus.instr, 0);
        chk({tag, "_opcode"}, {25'b0, bus.opcode}, 0);
        chk({tag, "_pc_out"}, bus.pc_out, 0);
        chk({tag, "_err"}, bus.fetch_err, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        reset_outputs_chk("rst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("req_at_release", bus.imem_req, 0);
        @(negedge clk);
        chk("req_after_release", bus.imem_req, 1);
        chk("addr_after_release", bus.imem_addr, 32'h0);
    endtask

    logic [31:0] model_pc;
    logic [31:0] nxt;
    logic [31:0] tgt;
    logic [31:0] w;
    bit          tk;

    initial begin
        rst_n = 1'b0;
        bus.imem_gnt      = 1'b0;
        bus.imem_rvalid   = 1'b0;
        bus.imem_rdata    = 32'h0;
        bus.instr_ready   = 1'b0;
        bus.branch_taken  = 1'b0;
        bus.branch_target = 32'h0;

        vecs[0] = '{0, 0, 0, 0, 0, 32'h0,   32'h0050_0093, 32'h00, 32'h04};
        vecs[1] = '{0, 0, 5, 0, 0, 32'h0,   32'h0050_0093, 32'h04, 32'h08};
        vecs[2] = '{4, 3, 0, 0, 0, 32'h0,   32'h00A0_0113, 32'h08, 32'h0C};
        vecs[3] = '{0, 0, 0, 0, 0, 32'h0,   32'h0020_8463, 32'h0C, 32'h10};
        vecs[4] = '{1, 1, 0, 0, 1, 32'h40,  32'h0020_8463, 32'h10, 32'h40};
        vecs[5] = '{0, 0, 1, 0, 0, 32'h0,   32'h0000_0037, 32'h40, 32'h44};
        vecs[6] = '{0, 2, 0, 1, 0, 32'h0,   32'h0000_0017, 32'h44, 32'h48};
        vecs[7] = '{2, 0, 2, 0, 1, 32'h100, 32'h0000_006F, 32'h48, 32'h100};

        #1;
        reset_outputs_chk("por");
        do_reset();

        for (int i = 0; i < 8; i++) begin
            fetch(vecs[i].gd, vecs[i].rd, vecs[i].hd, vecs[i].stale, vecs[i].tk,
                  vecs[i].tgt, vecs[i].word, vecs[i].exp_addr, vecs[i].exp_next, 1'b0);
        end

        // Randomized transactions against the architectural PC rule
        model_pc = 32'h100;
        for (int i = 0; i < 40; i++) begin
            tk  = bit'($urandom_range(0, 1));
            tgt = $urandom;
`ifdef FETCH_MISALIGN_CHECK_EN
            tgt[1:0] = 2'b00;
`endif
            w   = $urandom;
            nxt = tk ? tgt : model_pc + 32'd4;
            fetch($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2),
                  bit'($urandom_range(0, 1)), tk, tgt, w, model_pc, nxt, 1'b0);
            model_pc = nxt;
        end

        // Misaligned branch target
`ifdef FETCH_MISALIGN_CHECK_EN
        fetch(0, 0, 0, 0, 1, 32'h42, 32'h0000_0063, model_pc, 32'h42, 1'b1);
        for (int i = 0; i < 6; i++) begin
            bus.imem_gnt = 1'b1;
            bus.instr_ready = 1'b1;
            @(negedge clk);
            chk("err_sticky_req", bus.imem_req, 0);
            chk("err_sticky_flag", bus.fetch_err, 1);
            chk("err_sticky_valid", bus.instr_valid, 0);
        end
        bus.imem_gnt = 1'b0;
        bus.instr_ready = 1'b0;
`else
        fetch(0, 0, 0, 0, 1, 32'h42, 32'h0000_0063, model_pc, 32'h42, 1'b0);
`endif

        // Reset mid-WAIT, then a late rvalid in REQ must be dropped
        do_reset();
        fetch(0, 0, 0, 0, 0, 32'h0, 32'h0050_0093, 32'h0, 32'h4, 1'b0);
        bus.imem_gnt = 1'b1;
        @(negedge clk);
        bus.imem_gnt = 1'b0;
        rst_n = 1'b0;
        #1;
        reset_outputs_chk("wait_rst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_req", bus.imem_req, 1);
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'h1234_5678;
        @(negedge clk);
        bus.imem_rvalid = 1'b0;
        chk("stale_dropped_valid", bus.instr_valid, 0);
        chk("stale_dropped_req", bus.imem_req, 1);
        chk("stale_dropped_addr", bus.imem_addr, 32'h0);
        fetch(0, 0, 0, 0, 0, 32'h0, 32'h00A0_0113, 32'h0, 32'h4, 1'b0);

        // Reset mid-HOLD loses the held instruction
        bus.imem_gnt = 1'b1;
        @(negedge clk);
        bus.imem_gnt = 1'b0;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'h0000_0033;
        @(negedge clk);
        bus.imem_rvalid = 1'b0;
        chk("pre_hold_rst_valid", bus.instr_valid, 1);
        rst_n = 1'b0;
        #1;
        reset_outputs_chk("hold_rst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Wrap DUT started at 0xFFFF_FFFC
        chk("wrap_log_size_ok", (w_log.size() >= 2) ? 32'd1 : 32'd0, 32'd1);
        if (w_log.size() >= 2) begin
            chk("wrap_first_addr", w_log[0], 32'hFFFF_FFFC);
            chk("wrap_second_addr", w_log[1], 32'h0000_0000);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
